// File: rtl/neuron_accum_pkg.sv
// ---------------------------------------------------------------------------
// neuron_accum_pkg
// Shared constants and types for the neuron accumulator and the sigmoid LUT
// stage that consumes its address.
//   NA_DATA_W         : width of signed Q8.8 operands
//   NA_FRAC_BITS      : fraction bits of the Q8.8 operands
//   NA_ADDR_W         : sigmoid LUT address width
//   NA_LUT_STEP_SHIFT : right shift from a Q.16 sum to a LUT index
//   NA_LUT_MID        : LUT midpoint (address of input 0.0)
//   state_e           : accumulator control states
// ---------------------------------------------------------------------------
package neuron_accum_pkg;

   localparam int NA_DATA_W         = 16;
   localparam int NA_FRAC_BITS      = 8;
   localparam int NA_ADDR_W         = 10;
   localparam int NA_LUT_STEP_SHIFT = 10;
   localparam int NA_LUT_MID        = 2 ** (NA_ADDR_W - 1);

   typedef enum logic [1:0] {
      ST_ACCUM,
      ST_DRAIN,
      ST_QUANT,
      ST_OUT
   } state_e;

   // Offset-binary midpoint for a LUT of the given address width.
   function automatic int lut_mid(input int addr_w);
      return 2 ** (addr_w - 1);
   endfunction

endpackage

// File: rtl/neuron_accum_if.sv
// ---------------------------------------------------------------------------
// neuron_accum_if
// Groups the pair-input stream and the LUT-address stream of neuron_accum.
//   io_bias                    : signed Q8.8 bias (sampled on first beat)
//   io_in_valid/ready          : input pair handshake
//   io_in_x, io_in_w           : signed Q8.8 activation and weight
//   io_in_last                 : marks the final pair of an evaluation
//   io_addr_valid/ready        : LUT address handshake
//   io_addr, io_sat            : LUT address and clamp flag
//   io_len_err                 : sticky pair-count mismatch flag
// master = upstream/downstream environment, slave = neuron_accum.
// ---------------------------------------------------------------------------
interface neuron_accum_if
   import neuron_accum_pkg::*;
#(
   parameter int DATA_W = NA_DATA_W,
   parameter int ADDR_W = NA_ADDR_W
);

   logic signed [DATA_W-1:0] io_bias;
   logic                     io_in_valid;
   logic                     io_in_ready;
   logic signed [DATA_W-1:0] io_in_x;
   logic signed [DATA_W-1:0] io_in_w;
   logic                     io_in_last;
   logic                     io_addr_valid;
   logic                     io_addr_ready;
   logic [ADDR_W-1:0]        io_addr;
   logic                     io_sat;
   logic                     io_len_err;

   modport master (
      output io_bias, io_in_valid, io_in_x, io_in_w, io_in_last, io_addr_ready,
      input  io_in_ready, io_addr_valid, io_addr, io_sat, io_len_err
   );

   modport slave (
      input  io_bias, io_in_valid, io_in_x, io_in_w, io_in_last, io_addr_ready,
      output io_in_ready, io_addr_valid, io_addr, io_sat, io_len_err
   );

endinterface

// File: rtl/neuron_accum_sat_addr_quant.sv
// ---------------------------------------------------------------------------
// sat_addr_quant
// Combinational conversion of a signed Q.16 accumulator into an offset-binary
// LUT address: floor shift by SHIFT, add the LUT midpoint, clamp to the
// address range.
//   acc_i  : signed accumulator (ACC_W bits)
//   addr_o : clamped LUT address (ADDR_W bits)
//   sat_o  : 1 when the clamp changed the index
// ---------------------------------------------------------------------------
module sat_addr_quant
   import neuron_accum_pkg::*;
#(
   parameter int ACC_W  = 40,
   parameter int ADDR_W = NA_ADDR_W,
   parameter int SHIFT  = NA_LUT_STEP_SHIFT
) (
   input  logic signed [ACC_W-1:0] acc_i,
   output logic [ADDR_W-1:0]       addr_o,
   output logic                    sat_o
);

   localparam logic signed [ACC_W-1:0] MID_C = ACC_W'(lut_mid(ADDR_W));
   localparam logic signed [ACC_W-1:0] TOP_C = ACC_W'((2 ** ADDR_W) - 1);

   // Returns {sat, addr}.
   function automatic logic [ADDR_W:0] clamp_idx(input logic signed [ACC_W-1:0] idx);
      logic [ADDR_W:0] res;
      if (idx[ACC_W-1]) begin
         res = {1'b1, {ADDR_W{1'b0}}};
      end else if (idx > TOP_C) begin
         res = {1'b1, {ADDR_W{1'b1}}};
      end else begin
         res = {1'b0, idx[ADDR_W-1:0]};
      end
      return res;
   endfunction

   logic signed [ACC_W-1:0] idx;

   always_comb begin
      // Arithmetic shift floors toward -inf, so negative sums stay monotonic.
      idx             = (acc_i >>> SHIFT) + MID_C;
      {sat_o, addr_o} = clamp_idx(idx);
   end

endmodule

// File: rtl/neuron_accum.sv
// ---------------------------------------------------------------------------
// neuron_accum
// Multiply-accumulates NUM_INPUTS signed Q8.8 (x, w) pairs plus a bias and
// emits a saturated sigmoid-LUT address.
//   clock : system clock
//   reset : asynchronous active-low reset
//   bus   : neuron_accum_if.slave (pair input stream, LUT address output,
//           sticky length-error flag)
// Pipeline: beat -> product register (p1) -> accumulator -> quantised address.
// Evaluations do not overlap; the input is stalled from the last beat until
// the address has been accepted downstream.
// ---------------------------------------------------------------------------
module neuron_accum
   import neuron_accum_pkg::*;
#(
   parameter int DATA_W         = NA_DATA_W,
   parameter int FRAC_BITS      = NA_FRAC_BITS,
   parameter int ACC_W          = 40,
   parameter int NUM_INPUTS     = 8,
   parameter int ADDR_W         = NA_ADDR_W,
   parameter int LUT_STEP_SHIFT = NA_LUT_STEP_SHIFT
) (
   input  logic          clock,
   input  logic          reset,
   neuron_accum_if.slave bus
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int CNT_W  = $clog2(NUM_INPUTS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_INPUTS - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_INPUTS);

   state_e                   state_q;
   logic [CNT_W-1:0]         cnt_q;
   logic signed [PROD_W-1:0] prod_p1_q;
   logic signed [PROD_W-1:0] prod_d;
   logic                     vld_p1_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  acc_d;
   logic [ADDR_W-1:0]        addr_q;
   logic                     sat_q;
   logic                     addr_vld_q;
   logic                     len_err_q;

   logic                     in_ready;
   logic                     beat;
   logic                     first_beat;
   logic                     last_beat;
   logic signed [ACC_W-1:0]  bias_ext;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc_base;
   logic [ADDR_W-1:0]        quant_addr;
   logic                     quant_sat;

   // Gated by reset so ready is low while reset is held and high as soon as
   // it is released, without waiting for a clock edge.
   assign in_ready   = reset & (state_q == ST_ACCUM) & (cnt_q < CNT_FULL);
   assign beat       = bus.io_in_valid & in_ready;
   assign first_beat = beat & (cnt_q == '0);
   assign last_beat  = (cnt_q == CNT_LAST);

   always_comb begin
      prod_d   = PROD_W'(bus.io_in_x) * PROD_W'(bus.io_in_w);
      bias_ext = ACC_W'(bus.io_bias) <<< FRAC_BITS;
      prod_ext = ACC_W'(prod_p1_q);
      // The first beat replaces the stale sum with the bias; the product
      // pipeline is empty at that point, so the add below is a no-op then.
      acc_base = first_beat ? bias_ext : acc_q;
      acc_d    = vld_p1_q ? (acc_base + prod_ext) : acc_base;
   end

   sat_addr_quant #(
      .ACC_W  (ACC_W),
      .ADDR_W (ADDR_W),
      .SHIFT  (LUT_STEP_SHIFT)
   ) u_quant (
      .acc_i  (acc_q),
      .addr_o (quant_addr),
      .sat_o  (quant_sat)
   );

   // Stage p1: product register, data only.
   always_ff @(posedge clock) begin
      if (beat) begin
         prod_p1_q <= prod_d;
      end
   end

   // Control FSM, accumulator and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_ACCUM;
         cnt_q      <= '0;
         vld_p1_q   <= 1'b0;
         acc_q      <= '0;
         addr_q     <= '0;
         sat_q      <= 1'b0;
         addr_vld_q <= 1'b0;
         len_err_q  <= 1'b0;
      end else begin
         vld_p1_q <= beat;
         acc_q    <= acc_d;
         // Count governs the evaluation; a misplaced last only raises a flag.
         if (beat && (bus.io_in_last != last_beat)) begin
            len_err_q <= 1'b1;
         end
         case (state_q)
            ST_ACCUM: begin
               if (beat) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (last_beat) begin
                     state_q <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               state_q <= ST_QUANT;
            end
            ST_QUANT: begin
               addr_q     <= quant_addr;
               sat_q      <= quant_sat;
               addr_vld_q <= 1'b1;
               state_q    <= ST_OUT;
            end
            ST_OUT: begin
               if (bus.io_addr_ready) begin
                  addr_vld_q <= 1'b0;
                  cnt_q      <= '0;
                  state_q    <= ST_ACCUM;
               end
            end
            default: begin
               state_q <= ST_ACCUM;
            end
         endcase
      end
   end

   assign bus.io_in_ready   = in_ready;
   assign bus.io_addr_valid = addr_vld_q;
   assign bus.io_addr       = addr_q;
   assign bus.io_sat        = sat_q;
   assign bus.io_len_err    = len_err_q;

endmodule

// File: tb/tb_neuron_accum.sv
// ---------------------------------------------------------------------------
// tb_neuron_accum
// Self-checking bench for neuron_accum: table of uniform-pair evaluations,
// hand-written latency / back-pressure / length-error / reset sequences, and
// a scoreboard queue popped by an output monitor on each address handshake.
// ---------------------------------------------------------------------------
module tb_neuron_accum;
   import neuron_accum_pkg::*;

   localparam int NUM = 8;

   typedef struct packed {
      logic [9:0] addr;
      logic       sat;
   } exp_t;

   typedef struct {
      logic signed [15:0] bias;
      logic signed [15:0] x;
      logic signed [15:0] w;
      logic [9:0]         addr;
      logic               sat;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   exp_t               sb_q[$];
   logic signed [15:0] cur_x [NUM];
   logic signed [15:0] cur_w [NUM];
   vec_t               vecs [10];

   always #5 clk = ~clk;

   neuron_accum_if #(.DATA_W(16), .ADDR_W(10)) bus ();

   neuron_accum #(.NUM_INPUTS(NUM)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   function automatic void check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   // Reference: exact integer arithmetic on Q8.8 values, floor shift, clamp.
   function automatic exp_t model(input logic signed [15:0] bias);
      longint acc;
      longint idx;
      exp_t   r;
      acc = longint'(bias) * 256;
      for (int i = 0; i < NUM; i++) acc += longint'(cur_x[i]) * longint'(cur_w[i]);
      idx = (acc >>> 10) + 512;
      if (idx < 0) begin
         r.addr = 10'd0;    r.sat = 1'b1;
      end else if (idx > 1023) begin
         r.addr = 10'd1023; r.sat = 1'b1;
      end else begin
         r.addr = idx[9:0]; r.sat = 1'b0;
      end
      return r;
   endfunction

   // Output monitor: every address handshake must match the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.io_addr_valid && bus.io_addr_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got addr %0d, expected no output", bus.io_addr);
         end else begin
            e = sb_q.pop_front();
            check("addr", bus.io_addr, e.addr);
            check("sat", bus.io_sat, e.sat);
         end
      end
   end

   // Called at a negedge; returns at the negedge right after the beat.
   task automatic drive_beat(input logic signed [15:0] x, input logic signed [15:0] w,
                             input logic last, input int gap);
      int guard;
      bus.io_in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      bus.io_in_x     = x;
      bus.io_in_w     = w;
      bus.io_in_last  = last;
      bus.io_in_valid = 1'b1;
      guard = 0;
      while (!bus.io_in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got ready 0 for %0d cycles, expected 1", guard);
      end
      @(negedge clk);
      bus.io_in_valid = 1'b0;
      bus.io_in_last  = 1'b0;
   endtask

   task automatic run_pairs(input int last_at, input int max_gap);
      for (int i = 0; i < NUM; i++)
         drive_beat(cur_x[i], cur_w[i], i == last_at, (max_gap > 0) ? $urandom_range(max_gap, 0) : 0);
   endtask

   task automatic wait_drain(input string name);
      int guard;
      guard = 0;
      while (sb_q.size() != 0 && guard < 30) begin
         @(negedge clk);
         guard++;
      end
      check(name, sb_q.size(), 0);
      @(negedge clk);
   endtask

   task automatic randomize_pairs();
      for (int i = 0; i < NUM; i++) begin
         cur_x[i] = 16'($urandom);
         cur_w[i] = 16'($urandom);
      end
   endtask

   initial begin
      exp_t e;
      vecs[0] = '{bias:16'h0000, x:16'h0000, w:16'h0000, addr:10'd512,  sat:1'b0};
      vecs[1] = '{bias:16'h0040, x:16'h0000, w:16'h0000, addr:10'd528,  sat:1'b0};
      vecs[2] = '{bias:16'hFFC0, x:16'h0000, w:16'h0000, addr:10'd496,  sat:1'b0};
      vecs[3] = '{bias:16'h0000, x:16'hFF00, w:16'h0200, addr:10'd0,    sat:1'b1};
      vecs[4] = '{bias:16'h0000, x:16'h7F00, w:16'h7F00, addr:10'd1023, sat:1'b1};
      vecs[5] = '{bias:16'h0100, x:16'h0080, w:16'hFF80, addr:10'd448,  sat:1'b0};
      vecs[6] = '{bias:16'h07FC, x:16'h0000, w:16'h0000, addr:10'd1023, sat:1'b0};
      vecs[7] = '{bias:16'h0800, x:16'h0000, w:16'h0000, addr:10'd1023, sat:1'b1};
      vecs[8] = '{bias:16'hF800, x:16'h0000, w:16'h0000, addr:10'd0,    sat:1'b0};
      vecs[9] = '{bias:16'hF7FF, x:16'h0000, w:16'h0000, addr:10'd0,    sat:1'b1};

      bus.io_bias       = '0;
      bus.io_in_valid   = 1'b0;
      bus.io_in_x       = '0;
      bus.io_in_w       = '0;
      bus.io_in_last    = 1'b0;
      bus.io_addr_ready = 1'b1;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_in_ready", bus.io_in_ready, 0);
      check("rst_addr_valid", bus.io_addr_valid, 0);
      check("rst_addr", bus.io_addr, 0);
      check("rst_sat", bus.io_sat, 0);
      check("rst_len_err", bus.io_len_err, 0);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", bus.io_in_ready, 1);
      @(negedge clk);

      // Latency: 8 x (1.0 * 0.5) = 4.0 -> 768.
      for (int i = 0; i < NUM; i++) begin
         cur_x[i] = 16'h0100;
         cur_w[i] = 16'h0080;
      end
      bus.io_bias = 16'h0000;
      sb_q.push_back('{addr:10'd768, sat:1'b0});
      run_pairs(NUM - 1, 0);
      check("lat_t1_valid", bus.io_addr_valid, 0);
      @(negedge clk);
      check("lat_t2_valid", bus.io_addr_valid, 0);
      @(negedge clk);
      check("lat_t3_valid", bus.io_addr_valid, 1);
      check("lat_t3_in_ready", bus.io_in_ready, 0);
      @(negedge clk);
      check("lat_t4_in_ready", bus.io_in_ready, 1);
      check("lat_t4_valid", bus.io_addr_valid, 0);
      wait_drain("lat_drain");

      // Table of uniform-pair evaluations.
      for (int v = 0; v < 10; v++) begin
         for (int i = 0; i < NUM; i++) begin
            cur_x[i] = vecs[v].x;
            cur_w[i] = vecs[v].w;
         end
         bus.io_bias = vecs[v].bias;
         sb_q.push_back('{addr:vecs[v].addr, sat:vecs[v].sat});
         run_pairs(NUM - 1, 0);
         wait_drain("table_drain");
      end
      check("table_len_err", bus.io_len_err, 0);

      // Back-pressure: hold ready low, keep offering a pair that must be ignored.
      randomize_pairs();
      bus.io_bias = 16'($urandom);
      e = model(bus.io_bias);
      bus.io_addr_ready = 1'b0;
      sb_q.push_back(e);
      run_pairs(NUM - 1, 0);
      begin
         int guard;
         guard = 0;
         while (!bus.io_addr_valid && guard < 10) begin
            @(negedge clk);
            guard++;
         end
      end
      check("hold_valid_seen", bus.io_addr_valid, 1);
      bus.io_in_x     = 16'h7F00;
      bus.io_in_w     = 16'h7F00;
      bus.io_in_last  = 1'b1;
      bus.io_in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("hold_valid", bus.io_addr_valid, 1);
         check("hold_addr", bus.io_addr, e.addr);
         check("hold_sat", bus.io_sat, e.sat);
         check("hold_in_ready", bus.io_in_ready, 0);
      end
      @(posedge clk);
      #1 bus.io_addr_ready = 1'b1;
      @(negedge clk);
      check("hs_in_ready", bus.io_in_ready, 0);
      bus.io_in_valid = 1'b0;
      bus.io_in_last  = 1'b0;
      @(negedge clk);
      check("post_hs_in_ready", bus.io_in_ready, 1);
      check("post_hs_valid", bus.io_addr_valid, 0);
      check("hold_queue", sb_q.size(), 0);

      // A clean evaluation after back-pressure shows nothing was consumed.
      randomize_pairs();
      bus.io_bias = 16'($urandom);
      sb_q.push_back(model(bus.io_bias));
      run_pairs(NUM - 1, 0);
      wait_drain("post_hold_drain");
      check("post_hold_len_err", bus.io_len_err, 0);

      // Early last on the 3rd beat with random gaps: flag set, all 8 beats used.
      randomize_pairs();
      bus.io_bias = 16'($urandom);
      sb_q.push_back(model(bus.io_bias));
      run_pairs(2, 3);
      wait_drain("len_err_drain");
      check("len_err_set", bus.io_len_err, 1);
      randomize_pairs();
      bus.io_bias = 16'($urandom);
      sb_q.push_back(model(bus.io_bias));
      run_pairs(NUM - 1, 2);
      wait_drain("sticky_drain");
      check("len_err_sticky", bus.io_len_err, 1);

      // Reset after 4 beats discards the partial sum.
      bus.io_bias = 16'h0400;
      for (int i = 0; i < 4; i++) drive_beat(16'h7F00, 16'h7F00, 1'b0, 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", bus.io_in_ready, 0);
      check("mid_rst_valid", bus.io_addr_valid, 0);
      check("mid_rst_addr", bus.io_addr, 0);
      check("mid_rst_sat", bus.io_sat, 0);
      check("mid_rst_len_err", bus.io_len_err, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mid_rel_in_ready", bus.io_in_ready, 1);
      @(negedge clk);
      randomize_pairs();
      bus.io_bias = 16'($urandom);
      sb_q.push_back(model(bus.io_bias));
      run_pairs(NUM - 1, 1);
      wait_drain("post_rst_drain");
      check("post_rst_len_err", bus.io_len_err, 0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
